// File: rtl/branch_resolve_if.sv
// EX-stage branch/jump resolve bundle and the registered redirect it returns.
// master drives the resolving instruction; slave is the resolve unit.
interface branch_resolve_if;
  logic        i_ex_valid;
  logic        i_ex_is_br;
  logic        i_ex_is_jmp;
  logic [2:0]  i_ex_funct3;
  logic [31:0] i_ex_pc;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic        i_br_less;
  logic        i_br_equal;
  logic        i_stall;
  logic        o_br_un;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_flush;

  modport master (
    output i_ex_valid, i_ex_is_br, i_ex_is_jmp, i_ex_funct3,
    output i_ex_pc, i_ex_target, i_ex_pred_taken,
    output i_br_less, i_br_equal, i_stall,
    input  o_br_un, o_redirect, o_redirect_pc, o_flush
  );

  modport slave (
    input  i_ex_valid, i_ex_is_br, i_ex_is_jmp, i_ex_funct3,
    input  i_ex_pc, i_ex_target, i_ex_pred_taken,
    input  i_br_less, i_br_equal, i_stall,
    output o_br_un, o_redirect, o_redirect_pc, o_flush
  );
endinterface

// File: rtl/branch_resolve.sv
// Resolves EX-stage branches/jumps, drives registered redirect/flush,
// and trains a 2-bit BHT that supplies the fetch-stage prediction.
module branch_resolve #(
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_if_pc,
  output logic             o_if_pred_taken,
  branch_resolve_if.slave  ex,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mispred_count
);
  localparam int IW = $clog2(BHT_DEPTH);

  logic [1:0]    bht [BHT_DEPTH];
  logic [IW-1:0] if_idx;
  logic [IW-1:0] ex_idx;
  logic          legal;
  logic          taken;
  logic          fire;
  logic          br_ev;
  logic          jmp_ev;
  logic          mispred;
  logic [31:0]   dest;
  logic          unused;

  assign if_idx = i_if_pc[IW+1:2];
  assign ex_idx = ex.i_ex_pc[IW+1:2];
  assign unused = ^{i_if_pc[31:IW+2], i_if_pc[1:0],
                    ex.i_ex_pc[1:0]};

  assign o_if_pred_taken = bht[if_idx][1];
  assign ex.o_br_un      = ex.i_ex_funct3[1];

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    unique case (ex.i_ex_funct3)
      3'b000:         taken = ex.i_br_equal;
      3'b001:         taken = !ex.i_br_equal;
      3'b100, 3'b110: taken = ex.i_br_less;
      3'b101, 3'b111: taken = !ex.i_br_less;
      default:        legal = 1'b0;
    endcase
  end

  // Jump wins over branch when both flags are set.
  assign fire    = ex.i_ex_valid && !ex.i_stall;
  assign jmp_ev  = fire && ex.i_ex_is_jmp;
  assign br_ev   = fire && !ex.i_ex_is_jmp
                 && ex.i_ex_is_br && legal;
  assign mispred = br_ev && (taken != ex.i_ex_pred_taken);
  assign dest    = (jmp_ev || taken) ? ex.i_ex_target
                                     : ex.i_ex_pc + 32'd4;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex.o_redirect    <= 1'b0;
      ex.o_flush       <= 1'b0;
      ex.o_redirect_pc <= 32'd0;
    end else begin
      ex.o_redirect <= jmp_ev || mispred;
      ex.o_flush    <= jmp_ev || mispred;
      if (jmp_ev || mispred)
        ex.o_redirect_pc <= dest;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= 2'b01;
    end else if (br_ev) begin
      if (taken && bht[ex_idx] != 2'b11)
        bht[ex_idx] <= bht[ex_idx] + 2'b01;
      else if (!taken && bht[ex_idx] != 2'b00)
        bht[ex_idx] <= bht[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_br_count      <= '0;
      o_mispred_count <= '0;
    end else begin
      if (br_ev && o_br_count != '1)
        o_br_count <= o_br_count + CNT_W'(1);
      if (mispred && o_mispred_count != '1)
        o_mispred_count <= o_mispred_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected redirects are queued
// as each EX instruction is driven and compared after the clock edge.
module tb_branch_resolve;
  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_out;
  logic [15:0] br_cnt;
  logic [15:0] mis_cnt;

  branch_resolve_if ex ();

  branch_resolve #(.BHT_DEPTH(16), .CNT_W(16)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_if_pc         (if_pc),
    .o_if_pred_taken (pred_out),
    .ex              (ex.slave),
    .o_br_count      (br_cnt),
    .o_mispred_count (mis_cnt)
  );

  typedef struct {
    logic        red;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  m_bht [16];
  logic [15:0] m_br;
  logic [15:0] m_mis;
  logic [31:0] m_rpc;
  int          total;
  int          bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_br  = '0;
    m_mis = '0;
    m_rpc = '0;
  endtask

  task automatic step(input logic v, input logic br, input logic jmp,
                      input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pred,
                      input logic less, input logic eq,
                      input logic stall);
    exp_t e;
    exp_t g;
    logic tk;
    logic lg;
    int   idx;
    ex.i_ex_valid      = v;
    ex.i_ex_is_br      = br;
    ex.i_ex_is_jmp     = jmp;
    ex.i_ex_funct3     = f3;
    ex.i_ex_pc         = pc;
    ex.i_ex_target     = tgt;
    ex.i_ex_pred_taken = pred;
    ex.i_br_less       = less;
    ex.i_br_equal      = eq;
    ex.i_stall         = stall;
    if_pc              = pc;
    idx                = int'(pc[5:2]);
    #1;
    total++;
    if (ex.o_br_un !== f3[1]) begin
      bad++;
      $display("FAIL br_un got=%b want=%b", ex.o_br_un, f3[1]);
    end
    total++;
    if (pred_out !== m_bht[idx][1]) begin
      bad++;
      $display("FAIL pre_edge_pred pc=%h got=%b want=%b",
               pc, pred_out, m_bht[idx][1]);
    end
    lg = 1'b1;
    tk = 1'b0;
    case (f3)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd4, 3'd6: tk = less;
      3'd5, 3'd7: tk = !less;
      default: lg = 1'b0;
    endcase
    e.red = 1'b0;
    e.pc  = m_rpc;
    if (v && !stall) begin
      if (jmp) begin
        e.red = 1'b1;
        e.pc  = tgt;
      end else if (br && lg) begin
        if (m_br != 16'hFFFF) m_br++;
        if (tk != pred) begin
          e.red = 1'b1;
          e.pc  = tk ? tgt : pc + 32'd4;
          if (m_mis != 16'hFFFF) m_mis++;
        end
        if (tk && m_bht[idx] != 2'b11) m_bht[idx]++;
        if (!tk && m_bht[idx] != 2'b00) m_bht[idx]--;
      end
    end
    m_rpc = e.pc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ex.i_ex_valid = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty");
    end else begin
      g = exp_q.pop_front();
      if (ex.o_redirect !== g.red || ex.o_flush !== g.red
          || ex.o_redirect_pc !== g.pc) begin
        bad++;
        $display("FAIL redirect pc=%h got=%b/%b/%h want=%b/%b/%h",
                 pc, ex.o_redirect, ex.o_flush, ex.o_redirect_pc,
                 g.red, g.red, g.pc);
      end
    end
    total++;
    if (br_cnt !== m_br || mis_cnt !== m_mis) begin
      bad++;
      $display("FAIL counts got=%0d/%0d want=%0d/%0d",
               br_cnt, mis_cnt, m_br, m_mis);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
         1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex.i_ex_valid = 1'b0;
    ex.i_stall    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ex.o_redirect !== 1'b0 || ex.o_flush !== 1'b0
        || ex.o_redirect_pc !== 32'h0 || br_cnt !== 16'h0
        || mis_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%b/%h/%0d/%0d want=0",
               ex.o_redirect, ex.o_flush, ex.o_redirect_pc,
               br_cnt, mis_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      total++;
      if (pred_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_pred idx=%0d got=%b want=0", i, pred_out);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_beq_taken();
    step(1'b1, 1'b1, 1'b0, 3'b000, 32'h100, 32'h180,
         1'b0, 1'b0, 1'b1, 1'b0);
    if_pc = 32'h100;
    #1;
    total++;
    if (pred_out !== 1'b1 || dut.bht[0] !== 2'b10) begin
      bad++;
      $display("FAIL beq_pred got=%b/%b want=1/10",
               pred_out, dut.bht[0]);
    end
    idle();
  endtask

  task automatic test_bgeu();
    step(1'b1, 1'b1, 1'b0, 3'b111, 32'h200, 32'h280,
         1'b1, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  task automatic test_stall();
    step(1'b1, 1'b1, 1'b0, 3'b000, 32'h100, 32'h180,
         1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (dut.bht[0] !== m_bht[0]) begin
      bad++;
      $display("FAIL stall_bht got=%b want=%b", dut.bht[0], m_bht[0]);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b1, 1'b0, 3'b000, 32'h48, 32'h400,
           m_bht[2][1], 1'b0, (k < 4), 1'b0);
      if_pc = 32'h48;
      #1;
      total++;
      if (pred_out !== m_bht[2][1] || dut.bht[2] !== m_bht[2]) begin
        bad++;
        $display("FAIL sat k=%0d got=%b/%b want=%b/%b", k, pred_out,
                 dut.bht[2], m_bht[2][1], m_bht[2]);
      end
    end
    total++;
    if (m_bht[2] !== 2'b00 || dut.bht[2] !== 2'b00) begin
      bad++;
      $display("FAIL sat_final got=%b want=00", dut.bht[2]);
    end
  endtask

  task automatic test_jump_and_illegal();
    step(1'b1, 1'b1, 1'b1, 3'b000, 32'hFFFF_FFFC, 32'h0000_1000,
         1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'b010, 32'h44, 32'h800,
         1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'b011, 32'h44, 32'h800,
         1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'b001, 32'hFFFF_FFFC, 32'h40,
         1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 1'b0, 3'b100, 32'h300, 32'h340,
         1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'b110, 32'h304, 32'h380,
         1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'b000, 32'h308, 32'h500,
         1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'b101, 32'h30C, 32'h600,
         1'b0, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b0, 3'b000, 32'h20, 32'h700,
         1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ex.o_redirect !== 1'b0 || ex.o_flush !== 1'b0
        || ex.o_redirect_pc !== 32'h0
        || br_cnt !== 16'h0 || mis_cnt !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b/%h/%0d/%0d want=0",
               ex.o_redirect, ex.o_flush, ex.o_redirect_pc,
               br_cnt, mis_cnt);
    end
    model_reset();
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i) << 2;
      #0.2;
      total++;
      if (pred_out !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_pred idx=%0d got=%b want=0",
                 i, pred_out);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 3'b001, 32'h24, 32'h900,
         1'b0, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    if_pc = '0;
    ex.i_ex_valid      = 1'b0;
    ex.i_ex_is_br      = 1'b0;
    ex.i_ex_is_jmp     = 1'b0;
    ex.i_ex_funct3     = 3'd0;
    ex.i_ex_pc         = '0;
    ex.i_ex_target     = '0;
    ex.i_ex_pred_taken = 1'b0;
    ex.i_br_less       = 1'b0;
    ex.i_br_equal      = 1'b0;
    ex.i_stall         = 1'b0;
    test_reset();
    test_beq_taken();
    test_bgeu();
    test_stall();
    test_saturation();
    test_jump_and_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
